// File: rtl/pbkdf2_iter_ctrl_if.sv
// Request/response bus between the PBKDF2 iteration controller and hmac_sha256.
// Signal names follow the controller's point of view.
interface pbkdf2_iter_ctrl_if;
  logic [511:0] hmac_key_o;
  logic [511:0] hmac_msg_o;
  logic [5:0]   hmac_len_o;
  logic         hmac_v_o;
  logic         hmac_r_i;
  logic         hmac_v_i;
  logic         hmac_r_o;
  logic [255:0] hmac_prf_i;

  modport master (
    output hmac_key_o, hmac_msg_o, hmac_len_o, hmac_v_o, hmac_r_o,
    input  hmac_r_i, hmac_v_i, hmac_prf_i
  );

  modport slave (
    input  hmac_key_o, hmac_msg_o, hmac_len_o, hmac_v_o, hmac_r_o,
    output hmac_r_i, hmac_v_i, hmac_prf_i
  );
endinterface

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration controller: drives hmac_sha256 c times and
// XOR-accumulates the PRF outputs into the first derived-key block T1.
module pbkdf2_iter_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [511:0]       pw_i,
  input  logic [511:0]       salt_i,
  input  logic [5:0]         salt_len_i,
  input  logic [CNT_W-1:0]   iter_i,
  input  logic               v_i,
  output logic               r_o,
  output logic [255:0]       dk_o,
  output logic               v_o,
  input  logic               r_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   iter_done_o,
  pbkdf2_iter_ctrl_if.master hmac
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_t;

  state_t           state_reg;
  logic [255:0]     acc_reg;
  logic [255:0]     dk_reg;
  logic [CNT_W-1:0] c_reg;
  logic [CNT_W-1:0] iter_done_reg;
  logic [511:0]     key_reg;
  logic [511:0]     msg_reg;
  logic [5:0]       len_reg;
  logic             v_o_reg;
  logic             busy_reg;
  logic             hmac_v_reg;
  logic             hmac_r_reg;

  logic [5:0]       salt_len_clamped;
  logic [511:0]     salt_masked;
  logic [511:0]     first_msg;
  logic [CNT_W-1:0] iter_done_next;
  logic [255:0]     acc_next;

  assign salt_len_clamped = (salt_len_i > 6'd51) ? 6'd51 : salt_len_i;

  // Only the first salt_len bytes survive; INT(1) is OR-ed in right behind them.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_salt_mask
      assign salt_masked[511-8*gi -: 8] =
          (salt_len_clamped > 6'(gi)) ? salt_i[511-8*gi -: 8] : 8'h00;
    end
  endgenerate

  assign first_msg      = salt_masked | ({32'h0000_0001, 480'b0} >> {salt_len_clamped, 3'b000});
  assign iter_done_next = iter_done_reg + CNT_W'(1);
  assign acc_next       = acc_reg ^ hmac.hmac_prf_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      dk_reg        <= '0;
      c_reg         <= '0;
      iter_done_reg <= '0;
      key_reg       <= '0;
      msg_reg       <= '0;
      len_reg       <= '0;
      v_o_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      hmac_v_reg    <= 1'b0;
      hmac_r_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (v_i) begin
            key_reg       <= pw_i;
            msg_reg       <= first_msg;
            len_reg       <= salt_len_clamped + 6'd4;
            c_reg         <= (iter_i == '0) ? CNT_W'(1) : iter_i;
            iter_done_reg <= '0;
            acc_reg       <= '0;
            hmac_v_reg    <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (hmac.hmac_r_i) begin
            hmac_v_reg <= 1'b0;
            hmac_r_reg <= 1'b1;
            state_reg  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (hmac.hmac_v_i) begin
            acc_reg       <= acc_next;
            iter_done_reg <= iter_done_next;
            hmac_r_reg    <= 1'b0;
            if (iter_done_next == c_reg) begin
              dk_reg    <= acc_next;
              v_o_reg   <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              // Next U is HMAC(P, U_prev), so the message is the 32-byte PRF just received.
              msg_reg    <= {hmac.hmac_prf_i, 256'b0};
              len_reg    <= 6'd32;
              hmac_v_reg <= 1'b1;
              state_reg  <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          if (r_i) begin
            v_o_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign r_o              = (state_reg == ST_IDLE) && !rst_i;
  assign v_o              = v_o_reg;
  assign dk_o             = dk_reg;
  assign busy_o           = busy_reg;
  assign iter_done_o      = iter_done_reg;
  assign hmac.hmac_key_o  = key_reg;
  assign hmac.hmac_msg_o  = msg_reg;
  assign hmac.hmac_len_o  = len_reg;
  assign hmac.hmac_v_o    = hmac_v_reg;
  assign hmac.hmac_r_o    = hmac_r_reg;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Bench for pbkdf2_iter_ctrl: a behavioural HMAC-SHA256 core answers the controller,
// and derived keys are compared with RFC 6070-style vectors and a PBKDF2 reference.
module tb_pbkdf2_iter_ctrl;

  localparam logic [31:0] SHA_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] SHA_H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [511:0] PW   = {64'h70617373776f7264, 448'b0};
  localparam logic [511:0] SALT = {32'h73616c74, 480'b0};
  localparam logic [255:0] DK1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] DK2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [255:0] DK4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [511:0] pw_i, salt_i;
  logic [5:0]   salt_len_i;
  logic [31:0]  iter_i;
  logic         v_i, r_o, v_o, r_i, busy_o;
  logic [255:0] dk_o;
  logic [31:0]  iter_done_o;

  pbkdf2_iter_ctrl_if hif ();

  pbkdf2_iter_ctrl #(.CNT_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pw_i        (pw_i),
    .salt_i      (salt_i),
    .salt_len_i  (salt_len_i),
    .iter_i      (iter_i),
    .v_i         (v_i),
    .r_o         (r_o),
    .dk_o        (dk_o),
    .v_o         (v_o),
    .r_i         (r_i),
    .busy_o      (busy_o),
    .iter_done_o (iter_done_o),
    .hmac        (hif)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [255:0] hmac_sha256(input logic [511:0] key, input logic [511:0] msg, input int len);
    logic [511:0] blk;
    logic [255:0] ih;
    blk = '0;
    for (int i = 0; i < 56; i++) begin
      if (i < len) blk[511-8*i -: 8] = msg[511-8*i -: 8];
      else if (i == len) blk[511-8*i -: 8] = 8'h80;
    end
    blk[63:0] = 64'((64 + len) * 8);
    ih = sha_compress(sha_compress(SHA_H0, key ^ {64{8'h36}}), blk);
    return sha_compress(sha_compress(SHA_H0, key ^ {64{8'h5c}}), {ih, 8'h80, 184'b0, 64'd768});
  endfunction

  function automatic logic [511:0] ref_first_msg(input logic [511:0] salt, input int n);
    logic [511:0] m;
    logic [31:0]  one;
    m = '0;
    one = 32'h1;
    for (int i = 0; i < n; i++) m[511-8*i -: 8] = salt[511-8*i -: 8];
    for (int i = 0; i < 4; i++) m[511-8*(n+i) -: 8] = one[31-8*i -: 8];
    return m;
  endfunction

  function automatic logic [255:0] pbkdf2_ref(input logic [511:0] pw, input logic [511:0] salt,
                                              input int slen, input int iter);
    int n, c;
    logic [255:0] u, t;
    n = (slen > 51) ? 51 : slen;
    c = (iter == 0) ? 1 : iter;
    u = hmac_sha256(pw, ref_first_msg(salt, n), n + 4);
    t = u;
    for (int j = 1; j < c; j++) begin
      u = hmac_sha256(pw, {u, 256'b0}, 32);
      t ^= u;
    end
    return t;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[32*i +: 32] = $urandom;
    return x;
  endfunction

  // ---------------- behavioural HMAC core ----------------
  logic [511:0] job_pw, job_salt;
  int           job_n;
  int           emu_k, xfer_cnt, stall_left, emu_lat;
  bit           emu_busy, emu_pend;
  logic [511:0] pend_msg, xfer_msg, exp_msg;
  logic [255:0] emu_prf, emu_prev;
  int           exp_len;

  initial begin
    hif.hmac_r_i = 1'b0; hif.hmac_v_i = 1'b0; hif.hmac_prf_i = '0;
    emu_busy = 0; emu_pend = 0; emu_lat = 0; stall_left = 0; emu_k = 0; xfer_cnt = 0;
    emu_prev = '0; emu_prf = '0; pend_msg = '0; xfer_msg = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        emu_busy = 0; emu_pend = 0;
        hif.hmac_v_i = 1'b0; hif.hmac_r_i = 1'b0;
      end else if (!emu_busy) begin
        hif.hmac_v_i = 1'b0;
        if (stall_left > 0) begin
          stall_left--;
          hif.hmac_r_i = 1'b0;
        end else begin
          hif.hmac_r_i = ($urandom_range(3) != 0);
        end
        if (hif.hmac_v_o) begin
          if (!emu_pend) begin emu_pend = 1; pend_msg = hif.hmac_msg_o; end
          if (hif.hmac_r_i) begin
            check("send_stable", hif.hmac_msg_o, pend_msg);
            if (emu_k == 0) begin exp_msg = ref_first_msg(job_salt, job_n); exp_len = job_n + 4; end
            else begin exp_msg = {emu_prev, 256'b0}; exp_len = 32; end
            check("hmac_key", hif.hmac_key_o, job_pw);
            check("hmac_msg", hif.hmac_msg_o, exp_msg);
            check("hmac_len", 512'(hif.hmac_len_o), 512'(exp_len));
            xfer_msg = hif.hmac_msg_o;
            emu_prf  = hmac_sha256(hif.hmac_key_o, hif.hmac_msg_o, int'(hif.hmac_len_o));
            emu_lat  = $urandom_range(2);
            emu_busy = 1; emu_pend = 0;
            xfer_cnt++; emu_k++;
          end
        end
      end else begin
        hif.hmac_r_i = 1'b0;
        if (emu_lat > 0) begin
          emu_lat--;
        end else begin
          hif.hmac_v_i   = 1'b1;
          hif.hmac_prf_i = emu_prf;
          if (hif.hmac_r_o) begin
            check("wait_stable", hif.hmac_msg_o, xfer_msg);
            emu_busy = 0;
            emu_prev = emu_prf;
          end
        end
      end
    end
  end

  // ---------------- job driver ----------------
  task automatic start_job(input logic [511:0] pw, input logic [511:0] salt, input int slen,
                           input int iter, input int hstall);
    @(posedge clk_i); #1;
    job_pw = pw; job_salt = salt; job_n = (slen > 51) ? 51 : slen;
    emu_k = 0; xfer_cnt = 0; stall_left = hstall + 1;
    pw_i = pw; salt_i = salt; salt_len_i = 6'(slen); iter_i = 32'(iter); v_i = 1'b1;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    pw_i = rand512(); salt_i = rand512(); salt_len_i = 6'($urandom); iter_i = $urandom;
  endtask

  task automatic run_job(input logic [511:0] pw, input logic [511:0] salt, input int slen, input int iter,
                         input logic [255:0] exp_dk, input int hstall, input int rhold, input string tag);
    int eff, n;
    bit seen;
    eff = (iter == 0) ? 1 : iter;
    n   = (slen > 51) ? 51 : slen;
    @(negedge clk_i);
    check({tag, "_idle_rdy"}, 512'(r_o), 512'(1));
    start_job(pw, salt, slen, iter, hstall);
    @(negedge clk_i);
    check({tag, "_busy"}, 512'(busy_o), 512'(1));
    check({tag, "_rdy_low"}, 512'(r_o), 512'(0));
    check({tag, "_first_msg"}, hif.hmac_msg_o, ref_first_msg(salt, n));
    check({tag, "_first_len"}, 512'(hif.hmac_len_o), 512'(n + 4));
    seen = 0;
    for (int i = 0; i < eff * 12 + 100; i++) begin
      if (v_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    check({tag, "_done_seen"}, 512'(seen), 512'(1));
    if (!seen) begin
      @(posedge clk_i); #1 rst_i = 1'b1;
      @(posedge clk_i); #1 rst_i = 1'b0;
      return;
    end
    check({tag, "_dk"}, 512'(dk_o), 512'(exp_dk));
    check({tag, "_iter_done"}, 512'(iter_done_o), 512'(eff));
    check({tag, "_xfers"}, 512'(xfer_cnt), 512'(eff));
    $display("job %s iter=%0d xfers=%0d dk=%h", tag, iter, xfer_cnt, dk_o);
    repeat (rhold) @(posedge clk_i);
    @(negedge clk_i);
    check({tag, "_v_held"}, 512'(v_o), 512'(1));
    check({tag, "_dk_held"}, 512'(dk_o), 512'(exp_dk));
    @(posedge clk_i); #1 r_i = 1'b1;
    @(posedge clk_i); #1 r_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_v_drop"}, 512'(v_o), 512'(0));
    check({tag, "_idle"}, 512'({busy_o, r_o}), 512'(2'b01));
    check({tag, "_dk_kept"}, 512'(dk_o), 512'(exp_dk));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] rpw, rsalt;
    int rlen, rit;
    bit seen;
    rst_i = 1'b1; v_i = 1'b0; r_i = 1'b0;
    pw_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_r_o", 512'(r_o), 512'(0));
    check("rst_flags", 512'({v_o, busy_o, hif.hmac_v_o, hif.hmac_r_o}), 512'(0));
    check("rst_dk", 512'(dk_o), 512'(0));
    check("rst_iter_done", 512'(iter_done_o), 512'(0));
    check("rst_key", hif.hmac_key_o, 512'(0));
    check("rst_msg", hif.hmac_msg_o, 512'(0));
    check("rst_len", 512'(hif.hmac_len_o), 512'(0));
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_r_o_after", 512'(r_o), 512'(1));

    run_job(PW, SALT, 4, 1, DK1, 0, 0, "c1");
    run_job(PW, SALT, 4, 2, DK2, 5, 10, "c2_bp");
    run_job(PW, SALT, 4, 0, DK1, 0, 2, "c0");
    rpw = rand512(); rsalt = rand512();
    run_job(rpw, rsalt, 63, 2, pbkdf2_ref(rpw, rsalt, 63, 2), 1, 1, "slen63");

    // Reset while waiting on the third HMAC of a 10-iteration job.
    start_job(PW, SALT, 4, 10, 0);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (iter_done_o == 32'd2 && hif.hmac_r_o) begin seen = 1; break; end
    end
    check("mid_wait_seen", 512'(seen), 512'(1));
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_r_o", 512'(r_o), 512'(0));
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_flags", 512'({v_o, busy_o, hif.hmac_v_o, hif.hmac_r_o}), 512'(0));
    check("mid_iter_done", 512'(iter_done_o), 512'(0));
    check("mid_r_o", 512'(r_o), 512'(1));
    $display("job mid_rst reset applied iter_done=%0d", iter_done_o);
    run_job(PW, SALT, 4, 1, DK1, 0, 0, "post_rst");

    for (int j = 0; j < 6; j++) begin
      rpw = rand512(); rsalt = rand512();
      rlen = $urandom_range(63); rit = $urandom_range(4);
      run_job(rpw, rsalt, rlen, rit, pbkdf2_ref(rpw, rsalt, rlen, rit),
              $urandom_range(3), $urandom_range(4), $sformatf("rnd%0d", j));
    end

    run_job(PW, SALT, 4, 4096, DK4096, 0, 1, "c4096");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pbkdf2_iter_ctrl.md
Name: pbkdf2_iter_ctrl

Overview:
- Iteration controller for PBKDF2-HMAC-SHA256. Computes one 256-bit derived-key block, T1 = U1 ^ U2 ^ … ^ Uc, where U1 = HMAC(P, S || INT(1)) and Uj = HMAC(P, Uj-1).
- Sits directly upstream and downstream of hmac_sha256. It builds each HMAC key/message, issues it over the HMAC valid/ready handshake, consumes prf, XOR-accumulates it, and loops until the iteration count is reached.

Parameters:
CNT_W, 32, width of iteration count and progress counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
pw_i  in  512  password, left aligned, zero filled on the right
salt_i  in  512  salt, left aligned, zero filled; only the top 51 bytes are used
salt_len_i  in  6  salt length in bytes, 0..51
iter_i  in  CNT_W  iteration count c
v_i  in  1  job valid
r_o  out  1  controller ready for a job
dk_o  out  256  derived key block T1
v_o  out  1  dk_o valid
r_i  in  1  consumer ready for dk_o
busy_o  out  1  job in progress
iter_done_o  out  CNT_W  completed HMAC count for the current job
hmac_key_o  out  512  to hmac key_i
hmac_msg_o  out  512  to hmac msg_i
hmac_len_o  out  6  to hmac msg_len_i, in bytes
hmac_v_o  out  1  to hmac v_i
hmac_r_i  in  1  from hmac r_o
hmac_v_i  in  1  from hmac v_o
hmac_r_o  out  1  to hmac r_i
hmac_prf_i  in  256  from hmac prf_o

Behaviour:
- Handshake rule: a transfer occurs only on a cycle where valid and ready are both high. Applies to both job/result and HMAC sides.
- Reset values (rst_i high, and on the first cycle after):
  - state=IDLE; r_o=0 while rst_i high, 1 on the first cycle after.
  - v_o=0, busy_o=0, hmac_v_o=0, hmac_r_o=0.
  - dk_o=0, iter_done_o=0, accumulator=0, hmac_key_o/msg_o/len_o=0.
- States: IDLE, SEND, WAIT, DONE.
- IDLE: r_o=1. On v_i&r_o:
  - latch pw_i, salt_i and salt_len_i. salt_len_i > 51 is clamped to 51; salt bytes beyond the length are masked to 0.
  - c_reg = iter_i, with iter_i==0 treated as 1.
  - iter_done_o=0, acc=0; go to SEND.
- First message (iter_done_o==0):
  - msg = masked_salt | ({32'h00000001, 480'b0} >> (8*salt_len)).
  - len = salt_len + 4 (range 4..55).
- Later messages: msg = {U_prev, 256'b0}, len = 32.
- hmac_key_o = latched pw in every iteration.
- SEND: hmac_v_o=1; on hmac_v_o&hmac_r_i go to WAIT.
- Stability: hmac_key_o/msg_o/len_o are registered and change only on IDLE->SEND or WAIT->SEND. They stay stable from SEND entry until the result is accepted.
- WAIT: hmac_r_o=1. On hmac_v_i&hmac_r_o:
  - U_prev = hmac_prf_i; acc = acc ^ hmac_prf_i; iter_done_o += 1.
  - If the new iter_done_o == c_reg, go to DONE with dk_o = acc ^ hmac_prf_i; otherwise go to SEND with the next message.
- DONE: v_o=1, dk_o held. On v_o&r_i go to IDLE.
  - r_o stays 0 until IDLE, so no same-cycle job accept.
  - dk_o retains its value after v_o drops.
- busy_o = 1 in SEND, WAIT and DONE.
- Latency: per iteration = 1 (SEND, if hmac_r_i is already high) + HMAC latency + 1 (WAIT capture). Total ≈ c × (HMAC latency + 2) + 1 cycles to v_o.
- Ignored inputs: v_i outside IDLE, hmac_v_i outside WAIT, and r_i outside DONE have no effect.
- Reset mid-operation: the state is discarded and all outputs return to reset values on the next edge. The HMAC shares rst_i, so no stale prf is consumed.
- Counter arithmetic: iter_done_o is CNT_W wide; the comparison is exact equality. Maximum c = 2^CNT_W − 1; no wrap is possible because of the termination check.

Test Plan:
- c=1 vector: pw="password" (8 bytes), salt="salt", salt_len=4, iter=1 -> dk_o = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b. The first hmac_msg_o top 64 bits are 73616c7400000001, and hmac_len_o=8.
- c=2 vector: same inputs with iter=2 -> dk_o = ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43. Exactly 2 HMAC transfers; the second has hmac_len_o=32.
- c=4096 vector: same inputs with iter=4096 -> dk_o = c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a. iter_done_o reaches 4096 and exactly 4096 HMAC transfers occur.
- Edge inputs: iter=0 -> same dk_o as the c=1 vector. salt_len=63 -> treated as 51 (message length 55, INT(1) at bytes 51..54).
- Backpressure: hold hmac_r_i=0 for 5 cycles and r_i=0 for 10 cycles. hmac_msg_o must stay stable, v_o must stay high with dk_o unchanged, and the c=2 result must still be correct.
- Reset mid-run: assert rst_i for 1 cycle during WAIT of iteration 3 of a c=10 job. Next cycle v_o=0, busy_o=0, iter_done_o=0, r_o=1. A fresh c=1 job then yields the correct vector.
